// File: rtl/disp_pkg.sv
// Shared sizing constants and FSM state encoding for the disparity selector.
package disp_pkg;

  localparam int NCAND  = 16;
  localparam int NLANE  = 4;
  localparam int LANE_W = 14;
  localparam int COST_W = 16;
  localparam int WORD_W = NLANE * LANE_W;
  localparam int IDX_W  = $clog2(NCAND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cand_cost.sv
// Combinational cost of one candidate: sum of per-lane absolute differences.
module cand_cost
  import disp_pkg::*;
(
  input  logic [WORD_W-1:0] wg_i,
  input  logic [WORD_W-1:0] wfg_i,
  output logic [COST_W-1:0] cost_o
);

  // Lanes are unsigned; one extra sign bit makes the difference exact.
  function automatic logic [LANE_W-1:0] abs_lane(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
    logic signed [LANE_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_lane = d[LANE_W] ? LANE_W'(-d) : LANE_W'(d);
  endfunction

  logic [COST_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NLANE; k++) begin
      acc = acc + COST_W'(abs_lane(wg_i[k*LANE_W +: LANE_W],
                                   wfg_i[k*LANE_W +: LANE_W]));
    end
  end

  assign cost_o = acc;

endmodule

// File: rtl/disparity_select.sv
// Scans NCAND candidates one per cycle and reports the lowest-cost index
// (lowest index wins ties) with a single-cycle done pulse.
module disparity_select
  import disp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] wg0,
  input  logic [WORD_W-1:0] wg1,
  input  logic [WORD_W-1:0] wg2,
  input  logic [WORD_W-1:0] wg3,
  input  logic [WORD_W-1:0] wg4,
  input  logic [WORD_W-1:0] wg5,
  input  logic [WORD_W-1:0] wg6,
  input  logic [WORD_W-1:0] wg7,
  input  logic [WORD_W-1:0] wg8,
  input  logic [WORD_W-1:0] wg9,
  input  logic [WORD_W-1:0] wg10,
  input  logic [WORD_W-1:0] wg11,
  input  logic [WORD_W-1:0] wg12,
  input  logic [WORD_W-1:0] wg13,
  input  logic [WORD_W-1:0] wg14,
  input  logic [WORD_W-1:0] wg15,
  input  logic [WORD_W-1:0] wfg0,
  input  logic [WORD_W-1:0] wfg1,
  input  logic [WORD_W-1:0] wfg2,
  input  logic [WORD_W-1:0] wfg3,
  input  logic [WORD_W-1:0] wfg4,
  input  logic [WORD_W-1:0] wfg5,
  input  logic [WORD_W-1:0] wfg6,
  input  logic [WORD_W-1:0] wfg7,
  input  logic [WORD_W-1:0] wfg8,
  input  logic [WORD_W-1:0] wfg9,
  input  logic [WORD_W-1:0] wfg10,
  input  logic [WORD_W-1:0] wfg11,
  input  logic [WORD_W-1:0] wfg12,
  input  logic [WORD_W-1:0] wfg13,
  input  logic [WORD_W-1:0] wfg14,
  input  logic [WORD_W-1:0] wfg15,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  best_idx,
  output logic [COST_W-1:0] best_cost
);

  logic [WORD_W-1:0] wg_arr  [NCAND];
  logic [WORD_W-1:0] wfg_arr [NCAND];

  assign wg_arr[0]  = wg0;   assign wfg_arr[0]  = wfg0;
  assign wg_arr[1]  = wg1;   assign wfg_arr[1]  = wfg1;
  assign wg_arr[2]  = wg2;   assign wfg_arr[2]  = wfg2;
  assign wg_arr[3]  = wg3;   assign wfg_arr[3]  = wfg3;
  assign wg_arr[4]  = wg4;   assign wfg_arr[4]  = wfg4;
  assign wg_arr[5]  = wg5;   assign wfg_arr[5]  = wfg5;
  assign wg_arr[6]  = wg6;   assign wfg_arr[6]  = wfg6;
  assign wg_arr[7]  = wg7;   assign wfg_arr[7]  = wfg7;
  assign wg_arr[8]  = wg8;   assign wfg_arr[8]  = wfg8;
  assign wg_arr[9]  = wg9;   assign wfg_arr[9]  = wfg9;
  assign wg_arr[10] = wg10;  assign wfg_arr[10] = wfg10;
  assign wg_arr[11] = wg11;  assign wfg_arr[11] = wfg11;
  assign wg_arr[12] = wg12;  assign wfg_arr[12] = wfg12;
  assign wg_arr[13] = wg13;  assign wfg_arr[13] = wfg13;
  assign wg_arr[14] = wg14;  assign wfg_arr[14] = wfg14;
  assign wg_arr[15] = wg15;  assign wfg_arr[15] = wfg15;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [COST_W-1:0] min_cost_q, min_cost_d;
  logic [IDX_W-1:0]  min_idx_q, min_idx_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] wg_sel, wfg_sel;
  logic [COST_W-1:0] cost;
  logic              take;
  logic [COST_W-1:0] sel_cost;
  logic [IDX_W-1:0]  sel_idx;

  // Inputs are read live; upstream keeps them stable while busy.
  assign wg_sel  = wg_arr[cnt_q];
  assign wfg_sel = wfg_arr[cnt_q];

  cand_cost u_cand_cost (
    .wg_i   (wg_sel),
    .wfg_i  (wfg_sel),
    .cost_o (cost)
  );

  // Candidate 0 seeds the minimum; strict compare keeps the lowest index on ties.
  assign take     = (cnt_q == '0) || (cost < min_cost_q);
  assign sel_cost = take ? cost  : min_cost_q;
  assign sel_idx  = take ? cnt_q : min_idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    min_cost_d  = min_cost_q;
    min_idx_d   = min_idx_q;
    best_idx_d  = best_idx_q;
    best_cost_d = best_cost_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        min_cost_d = sel_cost;
        min_idx_d  = sel_idx;
        if (cnt_q == IDX_W'(NCAND - 1)) begin
          state_d     = DONE;
          best_idx_d  = sel_idx;
          best_cost_d = sel_cost;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      min_cost_q  <= '0;
      min_idx_q   <= '0;
      best_idx_q  <= '0;
      best_cost_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min_cost_q  <= min_cost_d;
      min_idx_q   <= min_idx_d;
      best_idx_q  <= best_idx_d;
      best_cost_q <= best_cost_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign best_idx  = best_idx_q;
  assign best_cost = best_cost_q;

endmodule

// File: tb/tb_disparity_select.sv
// Randomized and directed bench for disparity_select against a behavioural cost model.
module tb_disparity_select;
  import disp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [WORD_W-1:0] wg  [NCAND];
  logic [WORD_W-1:0] wfg [NCAND];
  logic              busy, done;
  logic [IDX_W-1:0]  best_idx;
  logic [COST_W-1:0] best_cost;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  disparity_select dut (
    .clk(clk), .rst(rst), .start(start),
    .wg0(wg[0]),   .wg1(wg[1]),   .wg2(wg[2]),   .wg3(wg[3]),
    .wg4(wg[4]),   .wg5(wg[5]),   .wg6(wg[6]),   .wg7(wg[7]),
    .wg8(wg[8]),   .wg9(wg[9]),   .wg10(wg[10]), .wg11(wg[11]),
    .wg12(wg[12]), .wg13(wg[13]), .wg14(wg[14]), .wg15(wg[15]),
    .wfg0(wfg[0]),   .wfg1(wfg[1]),   .wfg2(wfg[2]),   .wfg3(wfg[3]),
    .wfg4(wfg[4]),   .wfg5(wfg[5]),   .wfg6(wfg[6]),   .wfg7(wfg[7]),
    .wfg8(wfg[8]),   .wfg9(wfg[9]),   .wfg10(wfg[10]), .wfg11(wfg[11]),
    .wfg12(wfg[12]), .wfg13(wfg[13]), .wfg14(wfg[14]), .wfg15(wfg[15]),
    .busy(busy), .done(done), .best_idx(best_idx), .best_cost(best_cost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_cand(input int n, input int g, input int f);
    for (int k = 0; k < NLANE; k++) begin
      wg[n][k*LANE_W +: LANE_W]  = LANE_W'(g);
      wfg[n][k*LANE_W +: LANE_W] = LANE_W'(f);
    end
  endtask

  task automatic set_random(input int hi);
    for (int n = 0; n < NCAND; n++)
      for (int k = 0; k < NLANE; k++) begin
        wg[n][k*LANE_W +: LANE_W]  = LANE_W'($urandom_range(0, hi));
        wfg[n][k*LANE_W +: LANE_W] = LANE_W'($urandom_range(0, hi));
      end
  endtask

  function automatic int cand_cost_ref(input int n);
    int s = 0;
    for (int k = 0; k < NLANE; k++) begin
      int a = int'(wg[n][k*LANE_W +: LANE_W]);
      int b = int'(wfg[n][k*LANE_W +: LANE_W]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  // Minimum value first, then the first candidate that reaches it.
  task automatic ref_best(output int idx, output int cost);
    int c [NCAND];
    cost = 32'h7fffffff;
    for (int n = 0; n < NCAND; n++) begin
      c[n] = cand_cost_ref(n);
      if (c[n] < cost) cost = c[n];
    end
    idx = -1;
    for (int n = NCAND - 1; n >= 0; n--)
      if (c[n] == cost) idx = n;
  endtask

  task automatic do_scan(input string name, input int eidx, input int ecost,
                         input int ra, input int rb);
    int prev_i, prev_c, extra;
    bit seen;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    prev_i = int'(best_idx);
    prev_c = int'(best_cost);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (cyc == ra || cyc == rb) start = 1'b1;
      if (done) begin
        seen = 1'b1;
        chk({name, "_latency"}, cyc, 17);
        chk({name, "_idx"}, best_idx, eidx);
        chk({name, "_cost"}, best_cost, ecost);
        chk({name, "_busy_done"}, busy, 1);
      end else if (cyc == 1 || cyc == 8 || cyc == 16) begin
        chk({name, "_busy_scan"}, busy, 1);
        chk({name, "_hold_idx"}, best_idx, prev_i);
        chk({name, "_hold_cost"}, best_cost, prev_c);
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    chk({name, "_done_width"}, done, 0);
    chk({name, "_busy_after"}, busy, 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({name, "_extra_done"}, extra, 0);
    chk({name, "_keep_idx"}, best_idx, eidx);
    chk({name, "_keep_cost"}, best_cost, ecost);
  endtask

  task automatic model_scan(input string name, input int ra, input int rb);
    int ei, ec;
    ref_best(ei, ec);
    do_scan(name, ei, ec, ra, rb);
  endtask

  initial begin
    int extra;
    for (int n = 0; n < NCAND; n++) set_cand(n, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", best_idx, 0);
    chk("rst_cost", best_cost, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    do_scan("zero", 0, 0, -1, -1);

    for (int n = 0; n < NCAND; n++) set_cand(n, 100 + ((n > 9) ? n - 9 : 9 - n) * 5, 100);
    do_scan("vee", 9, 0, -1, -1);
    set_cand(9, 1000, 100);
    do_scan("vee_no9", 8, 20, -1, -1);

    for (int n = 0; n < NCAND; n++) set_cand(n, (n == 3 || n == 12) ? 2 : 10, 0);
    do_scan("tie", 3, 8, -1, -1);

    for (int n = 0; n < NCAND; n++) set_cand(n, 16383, 0);
    do_scan("maxcost", 0, 65532, -1, -1);

    set_random(16383);
    model_scan("rand0", -1, -1);
    set_random(16383);
    model_scan("rand1", -1, -1);
    set_random(3);
    model_scan("rand_tie0", -1, -1);
    set_random(3);
    model_scan("rand_tie1", -1, -1);

    set_random(16383);
    model_scan("restart", 5, 17);

    // Reset in the middle of a scan.
    set_random(16383);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_idx", best_idx, 0);
    chk("abort_cost", best_cost, 0);
    @(negedge clk) rst = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);
    chk("abort_idle", busy, 0);
    model_scan("after_abort", -1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
